// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: alignment check, lane steering onto the data-memory
// req/ack bus, pipeline stall until acknowledge or timeout, right-justified load return.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        w,
  input  logic        h,
  input  logic        b,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        lsu_done,
  output logic [31:0] load_data,
  output logic        align_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  localparam logic [7:0] CntMax = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_cause_q, bus_cause_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [31:0] load_data_q, load_data_d;

  logic        is_word, is_half, misalign;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_sel;

  // All-zero size select is treated as a word access.
  assign is_word  = w | ~(w | h | b);
  assign is_half  = ~is_word & h;
  assign misalign = (is_word & (addr[1:0] != 2'b00)) | (is_half & addr[0]);

  always_comb begin
    if (is_word) begin
      be_new    = 4'b1111;
      wdata_new = wdata;
    end else if (is_half) begin
      be_new    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{wdata[15:0]}};
    end else begin
      be_new    = 4'b0001 << addr[1:0];
      wdata_new = {4{wdata[7:0]}};
    end
  end

  // The registered byte enables already encode both size and lane.
  always_comb begin
    case (dm_be_q)
      4'b0011: load_sel = {16'h0, dm_rdata[15:0]};
      4'b1100: load_sel = {16'h0, dm_rdata[31:16]};
      4'b0001: load_sel = {24'h0, dm_rdata[7:0]};
      4'b0010: load_sel = {24'h0, dm_rdata[15:8]};
      4'b0100: load_sel = {24'h0, dm_rdata[23:16]};
      4'b1000: load_sel = {24'h0, dm_rdata[31:24]};
      default: load_sel = dm_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_cause_d = bus_cause_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_be_d     = dm_be_q;
    dm_wdata_d  = dm_wdata_q;
    load_data_d = load_data_q;
    stall       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_read | mem_write) begin
          stall = 1'b1;
          if (misalign) begin
            bus_cause_d = 1'b0;
            state_d     = StErr;
          end else begin
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_be_d    = be_new;
            dm_wdata_d = wdata_new;
            dm_we_d    = mem_write;
            dm_req_d   = 1'b1;
            cnt_d      = 8'd0;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        stall = 1'b1;
        if (dm_ack) begin
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          if (!dm_we_q) load_data_d = load_sel;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          dm_req_d    = 1'b0;
          dm_we_d     = 1'b0;
          bus_cause_d = 1'b1;
          state_d     = StErr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      bus_cause_q <= 1'b0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_be_q     <= 4'd0;
      dm_wdata_q  <= 32'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_cause_q <= bus_cause_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_be_q     <= dm_be_d;
      dm_wdata_q  <= dm_wdata_d;
      load_data_q <= load_data_d;
    end
  end

  assign lsu_done  = (state_q == StDone);
  assign align_err = (state_q == StErr) & ~bus_cause_q;
  assign bus_err   = (state_q == StErr) & bus_cause_q;
  assign load_data = load_data_q;
  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_be     = dm_be_q;
  assign dm_wdata  = dm_wdata_q;

endmodule
